// File: rtl/micro_seq_pkg.sv
// Shared types and constants for the micro-sequencer slice: the sequencer
// state enum, opcode field position, HALT opcode and address widths.
package micro_seq_pkg;

   localparam int INSTR_W = 22;
   localparam int OPC_MSB = 21;
   localparam int OPC_LSB = 18;
   localparam int UPC_W   = 8;
   localparam int SLOT_W  = 4;

   localparam logic [OPC_MSB-OPC_LSB:0] OPC_HALT = 4'b1111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      HALT = 2'd2
   } seqState_e;

   // Pull the opcode field out of a macro-instruction word.
   function automatic logic [OPC_MSB-OPC_LSB:0] opcodeOf(input logic [INSTR_W-1:0] instr);
      return instr[OPC_MSB:OPC_LSB];
   endfunction

endpackage

// File: rtl/micro_sequencer_prefetch_buf.sv
// One-entry instruction prefetch buffer (module instr_prefetch_buf). Holds a
// macro-instruction accepted while a routine is still running so the next
// routine can start without an IDLE bubble. Push only happens while empty
// and pop only while full, so the two never coincide.
module instr_prefetch_buf
   import micro_seq_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               push_i,
   input  logic               pop_i,
   input  logic [INSTR_W-1:0] data_i,
   output logic               full_o,
   output logic [INSTR_W-1:0] data_o
);

   logic               full_q;
   logic [INSTR_W-1:0] data_q;

   // Capture on push, release on pop; reset leaves the buffer empty.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         full_q <= 1'b0;
         data_q <= '0;
      end else if (push_i) begin
         full_q <= 1'b1;
         data_q <= data_i;
      end else if (pop_i) begin
         full_q <= 1'b0;
      end
   end

   assign full_o = full_q;
   assign data_o = data_q;

endmodule

// File: rtl/micro_sequencer.sv
// Micro-sequencer: accepts macro-instructions, steps a microcode address
// through the 16-entry slot selected by the opcode, and parks in HALT on the
// HALT opcode. Build option MICRO_SEQUENCER_PREFETCH_EN adds a one-entry
// prefetch buffer so back-to-back routines run with no IDLE bubble.
module micro_sequencer
   import micro_seq_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic [INSTR_W-1:0] instr_in,
   input  logic               instr_valid,
   output logic               instr_ready,
   input  logic               ucode_last,
   input  logic               stall,
   output logic [UPC_W-1:0]   upc_addr,
   output logic               uinstr_valid,
   output logic [INSTR_W-1:0] instr_q,
   output logic               busy,
   output logic               halted,
   output logic               err_overrun
);

   seqState_e          state_q, state_d;
   logic [UPC_W-1:0]   upc_q, upc_d;
   logic [INSTR_W-1:0] instrLat_q, instrLat_d;
   logic               errOverrun_q, errOverrun_d;

   logic               accept;
   logic               slotEnd;
   logic               routineEnd;
   logic               startValid;
   logic [INSTR_W-1:0] startInstr;

`ifdef MICRO_SEQUENCER_PREFETCH_EN
   logic               bufFull;
   logic               bufPush;
   logic               bufPop;
   logic [INSTR_W-1:0] bufData;

   // A transfer during EXEC is parked unless the routine ends on the same
   // edge, in which case it is started directly instead.
   assign bufPush = accept && (state_q == EXEC) && !routineEnd;
   assign bufPop  = routineEnd && bufFull;

   instr_prefetch_buf uPrefetchBuf (
      .clk    (clk),
      .reset  (reset),
      .push_i (bufPush),
      .pop_i  (bufPop),
      .data_i (instr_in),
      .full_o (bufFull),
      .data_o (bufData)
   );
`endif

   assign accept     = instr_valid && instr_ready;
   assign slotEnd    = (upc_q[SLOT_W-1:0] == {SLOT_W{1'b1}});
   assign routineEnd = (state_q == EXEC) && !stall && (ucode_last || slotEnd);

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Address, latched instruction and sticky overrun flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         upc_q        <= '0;
         instrLat_q   <= '0;
         errOverrun_q <= 1'b0;
      end else begin
         upc_q        <= upc_d;
         instrLat_q   <= instrLat_d;
         errOverrun_q <= errOverrun_d;
      end
   end

   // Next state: step or end the routine, then start a new one if an
   // instruction is available (fresh transfer or buffered entry).
   always_comb begin
      state_d      = state_q;
      upc_d        = upc_q;
      instrLat_d   = instrLat_q;
      errOverrun_d = errOverrun_q;
      startValid   = 1'b0;
      startInstr   = instr_in;
      case (state_q)
         IDLE: begin
            startValid = accept;
         end
         EXEC: begin
            if (routineEnd) begin
               state_d = IDLE;
               upc_d   = '0;
               if (slotEnd && !ucode_last) begin
                  errOverrun_d = 1'b1;
               end
`ifdef MICRO_SEQUENCER_PREFETCH_EN
               if (bufFull) begin
                  startValid = 1'b1;
                  startInstr = bufData;
               end else begin
                  startValid = accept;
               end
`endif
            end else if (!stall) begin
               upc_d = {upc_q[UPC_W-1:SLOT_W], upc_q[SLOT_W-1:0] + SLOT_W'(1)};
            end
         end
         HALT: begin
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (startValid) begin
         instrLat_d = startInstr;
         if (opcodeOf(startInstr) == OPC_HALT) begin
            state_d = HALT;
            upc_d   = '0;
         end else begin
            state_d = EXEC;
            upc_d   = {opcodeOf(startInstr), {SLOT_W{1'b0}}};
         end
      end
   end

   // Outputs decoded from state; with prefetch the block keeps accepting
   // during EXEC until the buffer is occupied.
   always_comb begin
      instr_ready  = 1'b0;
      uinstr_valid = 1'b0;
      busy         = 1'b1;
      halted       = 1'b0;
      case (state_q)
         IDLE: begin
            instr_ready = 1'b1;
            busy        = 1'b0;
         end
         EXEC: begin
            uinstr_valid = 1'b1;
`ifdef MICRO_SEQUENCER_PREFETCH_EN
            instr_ready  = !bufFull;
`endif
         end
         HALT: begin
            halted = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign upc_addr    = upc_q;
   assign instr_q     = instrLat_q;
   assign err_overrun = errOverrun_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Testbench for micro_sequencer: table of per-cycle input/expected-output
// records, plus hand-written sequences for the asynchronous mid-routine
// reset and (when MICRO_SEQUENCER_PREFETCH_EN is defined) prefetch handoff.
module tb_micro_sequencer;
   import micro_seq_pkg::*;

`ifdef MICRO_SEQUENCER_PREFETCH_EN
   localparam logic PF = 1'b1;
`else
   localparam logic PF = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [21:0] instr_in;
   logic        instr_valid;
   logic        instr_ready;
   logic        ucode_last;
   logic        stall;
   logic [7:0]  upc_addr;
   logic        uinstr_valid;
   logic [21:0] instr_q;
   logic        busy;
   logic        halted;
   logic        err_overrun;

   typedef struct {
      logic        rst;
      logic        vld;
      logic [21:0] instr;
      logic        last;
      logic        stl;
      logic [7:0]  eUpc;
      logic        eUv;
      logic        eRdy;
      logic        eBusy;
      logic        eHalt;
      logic        eErr;
      logic [21:0] eIq;
   } vec_t;

   vec_t tbl[$];
   int   total = 0;
   int   bad   = 0;

   micro_sequencer dut (
      .clk          (clk),
      .reset        (reset),
      .instr_in     (instr_in),
      .instr_valid  (instr_valid),
      .instr_ready  (instr_ready),
      .ucode_last   (ucode_last),
      .stall        (stall),
      .upc_addr     (upc_addr),
      .uinstr_valid (uinstr_valid),
      .instr_q      (instr_q),
      .busy         (busy),
      .halted       (halted),
      .err_overrun  (err_overrun)
   );

   // Free-running clock, 10 time-unit period.
   always #5 clk = ~clk;

   // Overall time limit so the run can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog got=timeout exp=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic vec_t mk(input logic rst, input logic vld, input logic [21:0] instr,
                               input logic last, input logic stl, input logic [7:0] eUpc,
                               input logic eUv, input logic eRdy, input logic eBusy,
                               input logic eHalt, input logic eErr, input logic [21:0] eIq);
      vec_t v;
      v.rst = rst;   v.vld = vld;   v.instr = instr; v.last = last; v.stl = stl;
      v.eUpc = eUpc; v.eUv = eUv;   v.eRdy = eRdy;   v.eBusy = eBusy;
      v.eHalt = eHalt; v.eErr = eErr; v.eIq = eIq;
      return v;
   endfunction

   function automatic void add(input vec_t v);
      tbl.push_back(v);
   endfunction

   task automatic checkOutput(input string name, input int row, input logic [21:0] got,
                              input logic [21:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s row=%0d got=%h exp=%h", name, row, got, exp);
      end
   endtask

   task automatic checkRow(input int row, input vec_t v);
      checkOutput("upc_addr",     row, 22'(upc_addr),     22'(v.eUpc));
      checkOutput("uinstr_valid", row, 22'(uinstr_valid), 22'(v.eUv));
      checkOutput("instr_ready",  row, 22'(instr_ready),  22'(v.eRdy));
      checkOutput("busy",         row, 22'(busy),         22'(v.eBusy));
      checkOutput("halted",       row, 22'(halted),       22'(v.eHalt));
      checkOutput("err_overrun",  row, 22'(err_overrun),  22'(v.eErr));
      checkOutput("instr_q",      row, instr_q,           v.eIq);
   endtask

   // Drive one cycle of inputs, let the edge happen, then check just after it.
   task automatic applyStimulus(input int row, input vec_t v);
      reset       = v.rst;
      instr_valid = v.vld;
      instr_in    = v.instr;
      ucode_last  = v.last;
      stall       = v.stl;
      @(posedge clk);
      #1;
      checkRow(row, v);
   endtask

   initial begin
      reset       = 1'b1;
      instr_valid = 1'b0;
      instr_in    = '0;
      ucode_last  = 1'b0;
      stall       = 1'b0;

      // Reset, then first idle cycle.
      add(mk(1,0,22'h0,0,0, 8'h00,0,1,0,0,0, 22'h0));
      add(mk(0,0,22'h0,0,0, 8'h00,0,1,0,0,0, 22'h0));
      // Opcode 3, ucode_last on third micro-step.
      add(mk(0,1,22'h0C0005,0,0, 8'h30,1,PF,1,0,0, 22'h0C0005));
      add(mk(0,0,22'h0,0,0,      8'h31,1,PF,1,0,0, 22'h0C0005));
      add(mk(0,0,22'h0,0,0,      8'h32,1,PF,1,0,0, 22'h0C0005));
      add(mk(0,0,22'h0,1,0,      8'h00,0,1,0,0,0,  22'h0C0005));
      // Stall beats ucode_last at 8'h21.
      add(mk(0,1,22'h080000,0,0, 8'h20,1,PF,1,0,0, 22'h080000));
      add(mk(0,0,22'h0,0,0,      8'h21,1,PF,1,0,0, 22'h080000));
      add(mk(0,0,22'h0,1,1,      8'h21,1,PF,1,0,0, 22'h080000));
      add(mk(0,0,22'h0,1,1,      8'h21,1,PF,1,0,0, 22'h080000));
      add(mk(0,0,22'h0,1,0,      8'h00,0,1,0,0,0,  22'h080000));
      // Opcode 2 running off the end of its slot.
      add(mk(0,1,22'h08ABCD,0,0, 8'h20,1,PF,1,0,0, 22'h08ABCD));
      for (int i = 1; i < 16; i++) begin
         add(mk(0,0,22'h0,0,0, 8'(32 + i),1,PF,1,0,0, 22'h08ABCD));
      end
      add(mk(0,0,22'h0,0,0,      8'h00,0,1,0,0,1,  22'h08ABCD));
      // Overrun flag survives a normal routine.
      add(mk(0,1,22'h0C0005,0,0, 8'h30,1,PF,1,0,1, 22'h0C0005));
      add(mk(0,0,22'h0,1,0,      8'h00,0,1,0,0,1,  22'h0C0005));
      // HALT parks the block, ignoring further offers, until reset.
      add(mk(0,1,22'h3C0000,0,0, 8'h00,0,0,1,1,1,  22'h3C0000));
      for (int i = 0; i < 20; i++) begin
         add(mk(0,1,22'h040000 + 22'(i),0,0, 8'h00,0,0,1,1,1, 22'h3C0000));
      end
      add(mk(1,0,22'h0,0,0,      8'h00,0,1,0,0,0,  22'h0));
      add(mk(0,0,22'h0,0,0,      8'h00,0,1,0,0,0,  22'h0));

      for (int r = 0; r < tbl.size(); r++) begin
         applyStimulus(r, tbl[r]);
      end

      // Asynchronous reset in the middle of an opcode-5 routine at 8'h52.
      applyStimulus(100, mk(0,1,22'h140000,0,0, 8'h50,1,PF,1,0,0, 22'h140000));
      applyStimulus(101, mk(0,0,22'h0,0,0,      8'h51,1,PF,1,0,0, 22'h140000));
      applyStimulus(102, mk(0,0,22'h0,0,0,      8'h52,1,PF,1,0,0, 22'h140000));
      #2;
      reset = 1'b1;
      #1;
      checkOutput("async_upc",    103, 22'(upc_addr),     22'h0);
      checkOutput("async_uvalid", 103, 22'(uinstr_valid), 22'h0);
      checkOutput("async_busy",   103, 22'(busy),         22'h0);
      checkOutput("async_halted", 103, 22'(halted),       22'h0);
      checkOutput("async_err",    103, 22'(err_overrun),  22'h0);
      checkOutput("async_iq",     103, instr_q,           22'h0);
      #1;
      reset = 1'b0;
      #1;
      checkOutput("post_rst_ready", 104, 22'(instr_ready), 22'h1);
      applyStimulus(105, mk(0,1,22'h0C0005,0,0, 8'h30,1,PF,1,0,0, 22'h0C0005));
      applyStimulus(106, mk(0,0,22'h0,1,0,      8'h00,0,1,0,0,0,  22'h0C0005));

`ifdef MICRO_SEQUENCER_PREFETCH_EN
      // Opcode 6 buffered during opcode 1, handed off with no bubble.
      applyStimulus(200, mk(0,1,22'h040000,0,0, 8'h10,1,1,1,0,0, 22'h040000));
      applyStimulus(201, mk(0,1,22'h180000,0,0, 8'h11,1,0,1,0,0, 22'h040000));
      applyStimulus(202, mk(0,0,22'h0,0,0,      8'h12,1,0,1,0,0, 22'h040000));
      applyStimulus(203, mk(0,0,22'h0,1,0,      8'h60,1,1,1,0,0, 22'h180000));
      applyStimulus(204, mk(0,0,22'h0,1,0,      8'h00,0,1,0,0,0, 22'h180000));
      // Transfer on the same edge as a routine end passes straight through.
      applyStimulus(205, mk(0,1,22'h040000,0,0, 8'h10,1,1,1,0,0, 22'h040000));
      applyStimulus(206, mk(0,1,22'h180001,1,0, 8'h60,1,1,1,0,0, 22'h180001));
      // Buffered HALT enters HALT at the routine end.
      applyStimulus(207, mk(0,1,22'h3C0000,0,0, 8'h61,1,0,1,0,0, 22'h180001));
      applyStimulus(208, mk(0,0,22'h0,1,0,      8'h00,0,0,1,1,0, 22'h3C0000));
      applyStimulus(209, mk(1,0,22'h0,0,0,      8'h00,0,1,0,0,0, 22'h0));
      applyStimulus(210, mk(0,0,22'h0,0,0,      8'h00,0,1,0,0,0, 22'h0));
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/micro_sequencer.md
MICRO_SEQUENCER -- requirements
Module: micro_sequencer

Interface
REQ-001 The block SHALL have exactly one clock; reset is asynchronous and active-high.
REQ-002 The block SHALL have these ports:
- clk  in  1  rising-edge clock
- reset  in  1  async active-high reset
- instr_in  in  22  macro-instruction word; opcode = instr_in[21:18]
- instr_valid  in  1  instr_in valid
- instr_ready  out  1  block accepts instr_in this cycle
- ucode_last  in  1  current microinstruction is the final one of its routine
- stall  in  1  hold the current micro-step
- upc_addr  out  8  microcode store address
- uinstr_valid  out  1  upc_addr addresses a live microinstruction
- instr_q  out  22  latched instruction, held stable for the whole routine (feeds the instruction-field merge stage)
- busy  out  1  state != IDLE
- halted  out  1  HALT state
- err_overrun  out  1  sticky routine-overrun flag

Function
REQ-003 The block SHALL implement states IDLE, EXEC and HALT.
REQ-004 In IDLE the block SHALL drive instr_ready=1 and uinstr_valid=0.
REQ-005 A transfer SHALL occur on a rising edge with instr_valid=1 and instr_ready=1; the block SHALL load instr_q with instr_in at that edge.
REQ-006 On a transfer of a non-HALT opcode, the block SHALL load upc_addr={opcode,4'b0000} and enter EXEC, giving uinstr_valid=1 one cycle after the accept edge.
REQ-007 On a transfer of opcode 4'b1111 (HALT), the block SHALL enter HALT and keep instr_ready=0 and uinstr_valid=0 until reset.
REQ-008 In EXEC with stall=1, the block SHALL hold upc_addr and state; stall SHALL take precedence over ucode_last.
REQ-009 In EXEC with stall=0 and ucode_last=0, the block SHALL increment upc_addr[3:0] by 1; upc_addr[7:4] SHALL stay unchanged.
REQ-010 In EXEC with stall=0 and ucode_last=1, the block SHALL end the routine, clear upc_addr to 0 and return to IDLE (subject to REQ-016).
REQ-011 In EXEC with stall=0, ucode_last=0 and upc_addr[3:0]=4'hF, the block SHALL end the routine as in REQ-010, with no wrap into the next slot, and SHALL set err_overrun.
REQ-012 err_overrun SHALL be cleared only by reset.
REQ-013 instr_q SHALL change only on a transfer edge.

Reset
REQ-014 Asserting reset at any time, including mid-routine, SHALL immediately set the state to IDLE and force outputs to: upc_addr=0, instr_q=0, uinstr_valid=0, busy=0, halted=0, err_overrun=0, and any prefetch buffer empty.
REQ-015 instr_ready SHALL be 1 in the first cycle after reset deassertion.

Configuration
REQ-016 Macro MICRO_SEQUENCER_PREFETCH_EN SHALL control a one-entry prefetch buffer as follows:
- Defined: in EXEC, instr_ready=1 while the buffer is empty. A transfer in EXEC fills the buffer.
- Defined: when a routine ends with the buffer full, the next edge SHALL load instr_q and upc_addr from the buffer and stay in EXEC. This is a zero-bubble transition.
- Defined: a buffered HALT SHALL enter HALT at that point.
- Defined: a transfer and a routine end on the same edge SHALL pass instr_in straight through as the next routine.
- Not defined: instr_ready=0 outside IDLE, and every routine is followed by at least one IDLE cycle.

Structure
REQ-017 The shared package micro_seq_pkg SHALL hold:
- the state enum
- OPC_MSB=21 and OPC_LSB=18
- OPC_HALT=4'b1111
- UPC_W=8 and SLOT_W=4
REQ-018 The prefetch buffer SHALL be the sub-module instr_prefetch_buf, instantiated only under MICRO_SEQUENCER_PREFETCH_EN.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Accept 22'h0C0005 (opcode 3), ucode_last on the 3rd micro-step -> upc_addr 8'h30, 8'h31, 8'h32, then IDLE with upc_addr=0. instr_q=22'h0C0005 throughout.
- stall=1 for 2 cycles at upc_addr 8'h21 with ucode_last=1 -> upc_addr holds 8'h21 for 3 cycles, then the routine ends.
- Opcode 2 with ucode_last never asserted -> upc_addr 8'h20..8'h2F, then IDLE with err_overrun=1, still 1 after the next routine.
- Accept 22'h3C0000 -> halted=1 and instr_ready=0 for 20 cycles; reset -> IDLE with instr_ready=1.
- Reset pulse while upc_addr=8'h52 -> all outputs zero in the same cycle, and a new accept works normally.
- PREFETCH_EN: a second instruction (opcode 6) accepted during opcode-1 EXEC -> upc_addr goes 8'h1x to 8'h60 on consecutive cycles with uinstr_valid held at 1.
